// File: rtl/mult_accumulator_pkg.sv
// Shared types and default sizes for the product accumulation stage of the MAC path.
package mult_acc_pkg;

  localparam int unsigned DEF_M     = 8;
  localparam int unsigned DEF_N     = 8;
  localparam int unsigned DEF_ACC_W = 20;
  localparam int unsigned DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/mult_accumulator_if.sv
// Product-in / sum-out handshake bundle; the accumulator takes the slave side.
interface mult_accumulator_if
  import mult_acc_pkg::*;
#(
  parameter int unsigned P_W   = DEF_M + DEF_N,
  parameter int unsigned ACC_W = DEF_ACC_W,
  parameter int unsigned CNT_W = DEF_CNT_W
);
  logic             in_valid;
  logic             in_ready;
  logic [P_W-1:0]   in_p;
  logic             in_last;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0] out_cnt;
  logic             out_ovf;

  modport master (
    output in_valid, in_p, in_last, acc_clr, out_ready,
    input  in_ready, out_valid, out_acc, out_cnt, out_ovf
  );

  modport slave (
    input  in_valid, in_p, in_last, acc_clr, out_ready,
    output in_ready, out_valid, out_acc, out_cnt, out_ovf
  );
endinterface

// File: rtl/mult_accumulator_rca.sv
// Plain ripple-carry adder; carry-out is exposed for overflow detection.
module RippleCarryAdder #(
  parameter int unsigned WIDTH = 20
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);
  always_comb begin
    logic c;
    c   = Cin;
    Sum = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      Sum[i] = A[i] ^ B[i] ^ c;
      c      = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
    end
    Cout = c;
  end
endmodule

// File: rtl/mult_accumulator.sv
// Sums groups of multiplier products closed by a last marker and holds each
// result, with term count and sticky overflow, until the consumer takes it.
module mult_accumulator
  import mult_acc_pkg::*;
#(
  parameter int unsigned M     = DEF_M,
  parameter int unsigned N     = DEF_N,
  parameter int unsigned ACC_W = DEF_ACC_W,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input logic              clk,
  input logic              reset,
  mult_accumulator_if.slave bus
);
  if (ACC_W < M + N) begin : g_width_check
    $error("mult_accumulator: ACC_W must be at least M+N");
  end

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] oacc_q, oacc_d;
  logic [CNT_W-1:0] ocnt_q, ocnt_d;
  logic             oovf_q, oovf_d;

  logic [ACC_W-1:0] add_a, add_b, sum;
  logic             carry;
  logic [CNT_W-1:0] base_cnt, cnt_next;
  logic             base_ovf, beat;

  // A clear coinciding with a beat restarts the group with that beat as term one.
  assign add_a    = bus.acc_clr ? '0 : acc_q;
  assign add_b    = ACC_W'(bus.in_p);
  assign base_cnt = bus.acc_clr ? '0 : cnt_q;
  assign base_ovf = bus.acc_clr ? 1'b0 : ovf_q;
  assign cnt_next = (base_cnt == '1) ? base_cnt : base_cnt + CNT_W'(1);
  assign beat     = bus.in_valid && (state_q != HOLD);

  RippleCarryAdder #(.WIDTH(ACC_W)) u_adder (
    .A   (add_a),
    .B   (add_b),
    .Cin (1'b0),
    .Sum (sum),
    .Cout(carry)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    oacc_d  = oacc_q;
    ocnt_d  = ocnt_q;
    oovf_d  = oovf_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (beat) begin
          if (bus.in_last) begin
            oacc_d  = sum;
            ocnt_d  = cnt_next;
            oovf_d  = base_ovf | carry;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = HOLD;
          end else begin
            acc_d   = sum;
            cnt_d   = cnt_next;
            ovf_d   = base_ovf | carry;
            state_d = ACCUM;
          end
        end else if (bus.acc_clr) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      oacc_q  <= '0;
      ocnt_q  <= '0;
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      oacc_q  <= oacc_d;
      ocnt_q  <= ocnt_d;
      oovf_q  <= oovf_d;
    end
  end

  assign bus.in_ready  = (state_q != HOLD);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_acc   = oacc_q;
  assign bus.out_cnt   = ocnt_q;
  assign bus.out_ovf   = oovf_q;
endmodule

// File: tb/tb_mult_accumulator.sv
// Directed bench for mult_accumulator: hand-computed sums, counts and overflow flags.
module tb_mult_accumulator;
  logic clk;
  logic reset;
  int   errors;
  int   checks;

  mult_accumulator_if #(.P_W(16), .ACC_W(20), .CNT_W(8)) bus ();

  mult_accumulator #(.M(8), .N(8), .ACC_W(20), .CNT_W(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; one rising edge samples them.
  task automatic send(input logic [15:0] p, input logic last, input logic clr);
    bus.in_valid = 1'b1;
    bus.in_p     = p;
    bus.in_last  = last;
    bus.acc_clr  = clr;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.acc_clr  = 1'b0;
    bus.in_p     = '0;
  endtask

  task automatic expect_result(input string tag, input logic [19:0] acc,
                               input logic [7:0] cnt, input logic ovf);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_acc"}, 32'(bus.out_acc), 32'(acc));
    chk({tag, "_cnt"}, 32'(bus.out_cnt), 32'(cnt));
    chk({tag, "_ovf"}, 32'(bus.out_ovf), 32'(ovf));
  endtask

  task automatic consume(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_done_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_done_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_p      = '0;
    bus.in_last   = 1'b0;
    bus.acc_clr   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_acc", 32'(bus.out_acc), 32'd0);
    chk("rst_cnt", 32'(bus.out_cnt), 32'd0);
    chk("rst_ovf", 32'(bus.out_ovf), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single term: result one edge after the last beat.
    send(16'd65025, 1'b1, 1'b0);
    expect_result("single", 20'd65025, 8'd1, 1'b0);
    @(negedge clk);
    expect_result("single_hold", 20'd65025, 8'd1, 1'b0);
    consume("single");

    // Sixteen terms, just below 2^20.
    for (int i = 0; i < 16; i++) send(16'd65025, (i == 15), 1'b0);
    expect_result("g16", 20'd1040400, 8'd16, 1'b0);
    consume("g16");

    // Seventeen terms wrap: 1105425 - 1048576 = 56849.
    for (int i = 0; i < 17; i++) send(16'd65025, (i == 16), 1'b0);
    expect_result("g17", 20'd56849, 8'd17, 1'b1);
    consume("g17");

    // Clear colliding with a last beat leaves a single-term group.
    for (int i = 0; i < 3; i++) send(16'd100, 1'b0, 1'b0);
    send(16'd7, 1'b1, 1'b1);
    expect_result("clrcol", 20'd7, 8'd1, 1'b0);

    // Backpressure in HOLD with a pending beat and clear.
    bus.in_valid = 1'b1;
    bus.in_p     = 16'd55;
    bus.in_last  = 1'b1;
    bus.acc_clr  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      expect_result("bp", 20'd7, 8'd1, 1'b0);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.acc_clr  = 1'b0;
    bus.in_p     = '0;
    consume("bp");
    send(16'd3, 1'b1, 1'b0);
    expect_result("after_bp", 20'd3, 8'd1, 1'b0);
    consume("after_bp");

    // Standalone clear discards the running group.
    send(16'd10, 1'b0, 1'b0);
    send(16'd20, 1'b0, 1'b0);
    bus.acc_clr = 1'b1;
    @(negedge clk);
    bus.acc_clr = 1'b0;
    chk("clr_ready", 32'(bus.in_ready), 32'd1);
    send(16'd5, 1'b1, 1'b0);
    expect_result("clr", 20'd5, 8'd1, 1'b0);
    consume("clr");

    // Term counter saturates at 255.
    for (int i = 0; i < 300; i++) send(16'd1, (i == 299), 1'b0);
    expect_result("sat", 20'd300, 8'd255, 1'b0);
    consume("sat");

    // Reset mid-group clears everything, including presented outputs.
    send(16'd500, 1'b0, 1'b0);
    send(16'd500, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_ready", 32'(bus.in_ready), 32'd1);
    chk("mrst_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_acc", 32'(bus.out_acc), 32'd0);
    chk("mrst_cnt", 32'(bus.out_cnt), 32'd0);
    send(16'd9, 1'b1, 1'b0);
    expect_result("mrst", 20'd9, 8'd1, 1'b0);
    consume("mrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench time limit exceeded");
  end
endmodule
